// File: rtl/range_stats_tracker_if.sv
// Sample/control/result bundle for range_stats_tracker.
// The bench or upstream logic drives through master; the tracker sits on slave.
interface range_stats_tracker_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic                 valid_in;
  logic                 go;
  logic                 finish;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     result;
  logic [CNT_WIDTH-1:0] count_out;
  logic                 result_valid;
  logic                 busy;
  logic                 overflow;
  logic                 error;

  modport master (
    output data_in, valid_in, go, finish, mode,
    input  result, count_out, result_valid, busy, overflow, error
  );

  modport slave (
    input  data_in, valid_in, go, finish, mode,
    output result, count_out, result_valid, busy, overflow, error
  );
endinterface

// File: rtl/range_stats_tracker.sv
// Framed min/max/count tracker with a mode-selected registered result.
// Frames open on a go rising edge and close on finish; protocol faults park in ERROR.
module range_stats_tracker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned SIGNED    = 0
) (
  input logic                  clock,
  input logic                  reset,
  range_stats_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]     ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     MIN_INIT = (SIGNED != 0) ? (ALL_ONES ^ MSB_ONLY) : ALL_ONES;
  localparam logic [WIDTH-1:0]     MAX_INIT = (SIGNED != 0) ? MSB_ONLY : {WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic                 go_prev_q;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [1:0]           mode_q, mode_d;
  logic                 pending_q, pending_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [CNT_WIDTH-1:0] count_out_q, count_out_d;
  logic                 result_valid_q, result_valid_d;
  logic                 go_pos;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     range_val;
  logic [WIDTH-1:0]     sel_val;

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) less = $signed(a) < $signed(b);
    else             less = a < b;
  endfunction

  assign go_pos = bus.go & ~go_prev_q;

  // Statistic selection from the committed min/max of the finished frame.
  always_comb begin
    if (SIGNED != 0) diff = {max_q[WIDTH-1], max_q} - {min_q[WIDTH-1], min_q};
    else             diff = {1'b0, max_q} - {1'b0, min_q};
    range_val = diff[WIDTH] ? ALL_ONES : diff[WIDTH-1:0];
    case (mode_q)
      2'b01:   sel_val = min_q;
      2'b10:   sel_val = max_q;
      default: sel_val = range_val;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d        = state_q;
    min_d          = min_q;
    max_d          = max_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    mode_d         = mode_q;
    pending_d      = 1'b0;
    result_d       = result_q;
    count_out_d    = count_out_q;
    result_valid_d = 1'b0;

    // Result commits one edge after the accepting finish edge.
    if (pending_q) begin
      result_d       = sel_val;
      count_out_d    = count_q;
      result_valid_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.finish && state_q != ERROR) begin
          state_d = ERROR;
        end else if (go_pos) begin
          state_d    = CHECK;
          overflow_d = 1'b0;
          count_d    = CNT_WIDTH'(bus.valid_in);
          min_d      = bus.valid_in ? bus.data_in : MIN_INIT;
          max_d      = bus.valid_in ? bus.data_in : MAX_INIT;
        end
      end
      CHECK: begin
        if (go_pos) begin
          state_d = ERROR;
        end else begin
          if (bus.valid_in) begin
            if (less(bus.data_in, min_q)) min_d = bus.data_in;
            if (less(max_q, bus.data_in)) max_d = bus.data_in;
            if (count_q == CNT_MAX) overflow_d = 1'b1;
            else                    count_d    = count_q + CNT_WIDTH'(1);
          end
          if (bus.finish) begin
            if (count_q == '0 && !bus.valid_in) begin
              state_d = ERROR;
            end else begin
              state_d   = DONE;
              pending_d = 1'b1;
              mode_d    = bus.mode;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      go_prev_q      <= 1'b0;
      min_q          <= MIN_INIT;
      max_q          <= MAX_INIT;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      mode_q         <= 2'b00;
      pending_q      <= 1'b0;
      result_q       <= '0;
      count_out_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      go_prev_q      <= bus.go;
      min_q          <= min_d;
      max_q          <= max_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      mode_q         <= mode_d;
      pending_q      <= pending_d;
      result_q       <= result_d;
      count_out_q    <= count_out_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.count_out    = count_out_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = (state_q == CHECK);
  assign bus.overflow     = overflow_q;
  assign bus.error        = (state_q == ERROR);

endmodule

// File: tb/tb_range_stats_tracker.sv
// Bench for range_stats_tracker: three configurations share one stimulus stream;
// a focus selector picks which instance the scoreboard and checks observe.
module tb_range_stats_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       go = 1'b0;
  logic       finish = 1'b0;
  logic [1:0] mode = 2'b00;

  int passed = 0;
  int total  = 0;
  int focus  = 0;

  always #5 clock = ~clock;

  range_stats_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) b0 ();
  range_stats_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) b1 ();
  range_stats_tracker_if #(.WIDTH(8), .CNT_WIDTH(2)) b2 ();

  assign b0.data_in = data_in; assign b0.valid_in = valid_in; assign b0.go = go;
  assign b0.finish = finish;   assign b0.mode = mode;
  assign b1.data_in = data_in; assign b1.valid_in = valid_in; assign b1.go = go;
  assign b1.finish = finish;   assign b1.mode = mode;
  assign b2.data_in = data_in; assign b2.valid_in = valid_in; assign b2.go = go;
  assign b2.finish = finish;   assign b2.mode = mode;

  range_stats_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(0)) u0 (.clock(clock), .reset(reset), .bus(b0));
  range_stats_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1)) u1 (.clock(clock), .reset(reset), .bus(b1));
  range_stats_tracker #(.WIDTH(8), .CNT_WIDTH(2), .SIGNED(0)) u2 (.clock(clock), .reset(reset), .bus(b2));

  logic [7:0] f_res, f_cnt;
  logic       f_rv, f_busy, f_ovf, f_err;

  always_comb begin
    case (focus)
      1: begin
        f_res = b1.result; f_cnt = b1.count_out; f_rv = b1.result_valid;
        f_busy = b1.busy; f_ovf = b1.overflow; f_err = b1.error;
      end
      2: begin
        f_res = b2.result; f_cnt = {6'd0, b2.count_out}; f_rv = b2.result_valid;
        f_busy = b2.busy; f_ovf = b2.overflow; f_err = b2.error;
      end
      default: begin
        f_res = b0.result; f_cnt = b0.count_out; f_rv = b0.result_valid;
        f_busy = b0.busy; f_ovf = b0.overflow; f_err = b0.error;
      end
    endcase
  end

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    int              f;
    logic [1:0]      m;
    int              n;
    logic [5:0][7:0] s;
    logic [7:0]      r;
    logic [7:0]      c;
    logic            o;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: every result_valid on the focus instance must match a queued frame.
  always @(negedge clock) begin
    if (!reset && f_rv) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", int'(f_res), int'(e.r));
        check("sb_count", int'(f_cnt), int'(e.c));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    go = 1'b0; valid_in = 1'b0; finish = 1'b0;
  endtask

  function automatic vec_t mk(input int f, input logic [1:0] m, input int n,
                              input logic [47:0] s, input logic [7:0] r,
                              input logic [7:0] c, input logic o);
    vec_t v;
    v.f = f; v.m = m; v.n = n; v.s = s; v.r = r; v.c = c; v.o = o;
    return v;
  endfunction

  task automatic drain();
    for (int k = 0; k < 6 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    focus = v.f;
    mode  = v.m;
    e.r = v.r; e.c = v.c;
    idle(); step();
    go = 1'b1; valid_in = 1'b1; data_in = v.s[0];
    step();
    go = 1'b0;
    for (int i = 1; i < v.n; i++) begin
      data_in = v.s[i];
      finish  = (i == v.n - 1);
      if (finish) exp_q.push_back(e);
      step();
    end
    if (v.n == 1) begin
      valid_in = 1'b0; finish = 1'b1;
      exp_q.push_back(e);
      step();
    end
    idle();
    drain();
    check("frame_overflow", int'(f_ovf), int'(v.o));
    check("frame_error", int'(f_err), 0);
    check("frame_busy", int'(f_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 2'b00, 4, {8'd0, 8'd0, 8'd40, 8'd90, 8'd5, 8'd20}, 8'd85, 8'd4, 1'b0);
    tbl[1]  = mk(0, 2'b01, 4, {8'd0, 8'd0, 8'd40, 8'd90, 8'd5, 8'd20}, 8'd5, 8'd4, 1'b0);
    tbl[2]  = mk(0, 2'b10, 4, {8'd0, 8'd0, 8'd40, 8'd90, 8'd5, 8'd20}, 8'd90, 8'd4, 1'b0);
    tbl[3]  = mk(0, 2'b11, 4, {8'd0, 8'd0, 8'd40, 8'd90, 8'd5, 8'd20}, 8'd85, 8'd4, 1'b0);
    tbl[4]  = mk(1, 2'b00, 3, {8'd0, 8'd0, 8'd0, 8'h9C, 8'h07, 8'hFD}, 8'd107, 8'd3, 1'b0);
    tbl[5]  = mk(1, 2'b00, 2, {8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'h7F}, 8'hFF, 8'd2, 1'b0);
    tbl[6]  = mk(1, 2'b01, 3, {8'd0, 8'd0, 8'd0, 8'h9C, 8'h07, 8'hFD}, 8'h9C, 8'd3, 1'b0);
    tbl[7]  = mk(1, 2'b10, 3, {8'd0, 8'd0, 8'd0, 8'h9C, 8'h07, 8'hFD}, 8'h07, 8'd3, 1'b0);
    tbl[8]  = mk(2, 2'b00, 5, {8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd4, 8'd3, 1'b1);
    tbl[9]  = mk(0, 2'b00, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd42}, 8'd0, 8'd1, 1'b0);
    tbl[10] = mk(0, 2'b00, 2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0}, 8'd255, 8'd2, 1'b0);
    tbl[11] = mk(2, 2'b01, 2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd9}, 8'd3, 8'd2, 1'b0);

    // Reset state
    focus = 0;
    step(); step();
    check("rst_result", int'(b0.result), 0);
    check("rst_count", int'(b0.count_out), 0);
    check("rst_rv", int'(b0.result_valid), 0);
    check("rst_busy", int'(b0.busy), 0);
    check("rst_ovf", int'(b0.overflow), 0);
    check("rst_error", int'(b0.error), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_frame(tbl[i]);

    // finish while IDLE, then finish ignored in ERROR
    focus = 0; mode = 2'b00;
    idle(); step();
    finish = 1'b1; step();
    check("idle_finish_error", int'(f_err), 1);
    step();
    check("error_ignores_finish", int'(f_err), 1);
    finish = 1'b0; step();

    // Recovery from ERROR with go held high across frame end; exact result latency
    go = 1'b1; valid_in = 1'b1; data_in = 8'd50; step();
    check("recover_busy", int'(f_busy), 1);
    check("recover_error", int'(f_err), 0);
    data_in = 8'd10; step();
    check("busy_mid_frame", int'(f_busy), 1);
    data_in = 8'd30; finish = 1'b1;
    exp_q.push_back(exp_t'({8'd40, 8'd3}));
    step();
    finish = 1'b0; valid_in = 1'b0;
    check("busy_after_finish", int'(f_busy), 0);
    check("rv_at_finish_edge", int'(f_rv), 0);
    step();
    check("rv_one_after", int'(f_rv), 1);
    check("held_result", int'(f_res), 40);
    check("held_count", int'(f_cnt), 3);
    step();
    check("rv_single_pulse", int'(f_rv), 0);
    step(); step();
    check("go_held_no_restart", int'(f_busy), 0);
    check("go_held_no_error", int'(f_err), 0);
    go = 1'b0; step();

    // go rise during CHECK discards the frame
    go = 1'b1; valid_in = 1'b1; data_in = 8'd1; step();
    go = 1'b0; data_in = 8'd2; step();
    go = 1'b1; data_in = 8'd3; step();
    check("go_in_check_error", int'(f_err), 1);
    idle(); finish = 1'b1; step(); finish = 1'b0; step(); step();
    check("discard_keeps_result", int'(f_res), 40);
    check("discard_still_error", int'(f_err), 1);

    // Zero-sample frame from ERROR
    go = 1'b1; valid_in = 1'b0; step();
    check("empty_frame_busy", int'(f_busy), 1);
    go = 1'b0; finish = 1'b1; step();
    finish = 1'b0;
    check("empty_frame_error", int'(f_err), 1);
    step(); step();
    check("empty_keeps_result", int'(f_res), 40);
    check("empty_keeps_count", int'(f_cnt), 3);

    // Reset mid-frame, then a single-sample frame
    go = 1'b1; valid_in = 1'b1; data_in = 8'd11; step();
    go = 1'b0; data_in = 8'd22; step();
    data_in = 8'd33; step();
    reset = 1'b1; idle();
    #2;
    check("midrst_result", int'(f_res), 0);
    check("midrst_count", int'(f_cnt), 0);
    check("midrst_busy", int'(f_busy), 0);
    check("midrst_error", int'(f_err), 0);
    check("midrst_ovf", int'(f_ovf), 0);
    check("midrst_rv", int'(f_rv), 0);
    step();
    reset = 1'b0;
    step();
    run_frame(mk(0, 2'b00, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd42}, 8'd0, 8'd1, 1'b0));

    step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
